rom_burst_arbiter: RTL and testbench

//  Shares one single-port synchronous ROM (1-cycle registered read) among N_REQ requesters.

---
 rtl/rom_arb_pkg.sv | 16 +
 rtl/rom_burst_arbiter_rr_pick.sv | 34 +++
 rtl/rom_burst_arbiter.sv | 137 +++++++++++++
 tb/tb_rom_burst_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_arb_pkg.sv
// Shared types and helpers for the ROM burst arbiter.
//   arb_state_t : FSM states (IDLE = arbitrating, BURST = issuing beats)
//   onehot()    : index -> one-hot vector, zero when idx is outside 0..n-1
package rom_arb_pkg;

    localparam int MAX_REQ = 8;

    typedef enum logic {IDLE, BURST} arb_state_t;

    function automatic logic [MAX_REQ-1:0] onehot(input int idx, input int n);
        logic [MAX_REQ-1:0] v;
        v = (idx >= 0 && idx < n) ? (MAX_REQ'(1) << idx) : '0;
        return v;
    endfunction

endpackage

// File: rtl/rom_burst_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req   : request vector
//   ptr   : highest-priority index this round
//   valid : any request present
//   idx   : first set bit at or above ptr, searched cyclically
// The request vector is duplicated so the cyclic search becomes one linear
// priority encode over 2*N bits with everything below ptr masked off.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          valid,
    output logic [PW-1:0] idx
);

    logic [2*N-1:0] masked;

    always_comb begin
        // NOTE: combinational blocks use blocking '=' and assign every output
        // a default first, so no path leaves a value held (no latch inferred).
        valid  = 1'b0;
        idx    = '0;
        masked = {req, req} & ({(2*N){1'b1}} << ptr);
        for (int i = 0; i < 2*N; i++) begin
            if (masked[i] && !valid) begin
                valid = 1'b1;
                idx   = PW'(i % N);
            end
        end
    end

endmodule

// File: rtl/rom_burst_arbiter.sv
// Round-robin burst arbiter in front of one single-port synchronous ROM.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : level request per requester
//   req_addr   : packed burst start addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_len    : packed burst lengths (beats-1), requester i at [i*LEN_WIDTH +: LEN_WIDTH]
//   gnt        : one-hot single-cycle pulse when a burst is accepted
//   rom_addr   : registered ROM address, one beat per clock while bursting
//   rom_q      : ROM read data, valid one cycle after rom_addr
//   rd_data    : rom_q passed through
//   rd_valid   : one-hot owner of rd_data this cycle
//   rd_last    : final beat of the burst
//   busy       : burst issuing or a beat still returning
module rom_burst_arbiter
    import rom_arb_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 3,
    parameter int LEN_WIDTH  = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [N_REQ*LEN_WIDTH-1:0]  req_len,
    output logic [N_REQ-1:0]            gnt,
    output logic [ADDR_WIDTH-1:0]       rom_addr,
    input  logic [DATA_WIDTH-1:0]       rom_q,
    output logic [DATA_WIDTH-1:0]       rd_data,
    output logic [N_REQ-1:0]            rd_valid,
    output logic                        rd_last,
    output logic                        busy
);

    localparam int PTR_W = $clog2(N_REQ);

    arb_state_t             state_q, state_d;
    logic [PTR_W-1:0]       owner_q, owner_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]  addr_d;
    logic [N_REQ-1:0]       gnt_d, rd_valid_d;
    logic                   rd_last_d;

    logic                   pick_valid;
    logic [PTR_W-1:0]       pick_idx;
    logic [ADDR_WIDTH-1:0]  addr_arr [N_REQ];
    logic [LEN_WIDTH-1:0]   len_arr  [N_REQ];
    logic [MAX_REQ-1:0]     pick_oh, owner_oh;

    rr_pick #(.N(N_REQ), .PW(PTR_W)) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            addr_arr[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            len_arr[i]  = req_len[i*LEN_WIDTH +: LEN_WIDTH];
        end
    end

    assign pick_oh  = onehot(int'(pick_idx), N_REQ);
    assign owner_oh = onehot(int'(owner_q), N_REQ);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state and datapath next values.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        addr_d     = rom_addr;
        gnt_d      = '0;
        rd_valid_d = '0;
        rd_last_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_idx;
                    cnt_d   = len_arr[pick_idx];
                    addr_d  = addr_arr[pick_idx];
                    gnt_d   = pick_oh[N_REQ-1:0];
                    // Winner becomes lowest priority for the next round.
                    ptr_d   = (pick_idx == PTR_W'(N_REQ-1)) ? '0 : pick_idx + PTR_W'(1);
                    state_d = BURST;
                end
            end
            BURST: begin
                // The address on rom_addr this cycle is an issued beat; its
                // data comes back next cycle, so the return tags are registered.
                rd_valid_d = owner_oh[N_REQ-1:0];
                rd_last_d  = (cnt_q == '0);
                if (cnt_q != '0) begin
                    addr_d = rom_addr + ADDR_WIDTH'(1);
                    cnt_d  = cnt_q - LEN_WIDTH'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking '<=' so every register
        // samples pre-edge values, independent of statement order.
        if (!rst_n) begin
            owner_q  <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            rom_addr <= '0;
            gnt      <= '0;
            rd_valid <= '0;
            rd_last  <= 1'b0;
        end else begin
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            rom_addr <= addr_d;
            gnt      <= gnt_d;
            rd_valid <= rd_valid_d;
            rd_last  <= rd_last_d;
        end
    end

    assign rd_data = rom_q;
    assign busy    = (state_q == BURST) | (|rd_valid);

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// Scoreboard bench for rom_burst_arbiter. ROM model: rom[a] = a ^ 3'b101.
module tb_rom_burst_arbiter;

    localparam int N  = 4;
    localparam int AW = 3;
    localparam int DW = 3;
    localparam int LW = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*LW-1:0] req_len = '0;
    logic [N-1:0]    gnt;
    logic [AW-1:0]   rom_addr;
    logic [DW-1:0]   rom_q = '0;
    logic [DW-1:0]   rd_data;
    logic [N-1:0]    rd_valid;
    logic            rd_last;
    logic            busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int         rid;
        logic [2:0] data;
        logic       last;
    } beat_t;

    beat_t sb[$];

    rom_burst_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_addr (req_addr),
        .req_len  (req_len),
        .gnt      (gnt),
        .rom_addr (rom_addr),
        .rom_q    (rom_q),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_last  (rd_last),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rom_q <= rom_addr ^ 3'b101;
        cyc   <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every presented beat must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && (|rd_valid)) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_beat: rd_valid %b rd_data %0d with empty scoreboard", rd_valid, rd_data);
            end else begin
                beat_t e;
                e = sb.pop_front();
                check("rd_valid", 32'(rd_valid), 32'(1) << e.rid);
                check("rd_data",  32'(rd_data),  32'(e.data));
                check("rd_last",  32'(rd_last),  32'(e.last));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic [2:0] addr, input logic [2:0] len);
        req[id] = 1'b1;
        req_addr[id*AW +: AW] = addr;
        req_len[id*LW +: LW] = len;
    endtask

    task automatic push(input int id, input logic [2:0] data, input logic last);
        beat_t b;
        b.rid  = id;
        b.data = data;
        b.last = last;
        sb.push_back(b);
    endtask

    // Returns at the negedge of the first cycle with any gnt bit set.
    task automatic wait_gnt(input int bound, output int at_cyc);
        int k;
        at_cyc = -1;
        for (k = 0; k < bound; k++) begin
            @(negedge clk);
            if (|gnt) begin
                at_cyc = cyc;
                break;
            end
        end
        if (at_cyc < 0) check("gnt_timeout", 32'(gnt), 32'hffff_ffff);
    endtask

    initial begin
        int gc;
        int prev;
        int order [5];
        logic [2:0] exp_a [3];

        // 1. reset and idle
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("idle_gnt", 32'(gnt), 0);
            check("idle_rd_valid", 32'(rd_valid), 0);
            check("idle_busy", 32'(busy), 0);
            check("idle_rom_addr", 32'(rom_addr), 0);
        end

        // 2. requester 1, addr 2, len 2: data 2^5, 3^5, 4^5 = 7, 6, 1
        step();
        set_req(1, 3'd2, 3'd2);
        push(1, 3'd7, 1'b0);
        push(1, 3'd6, 1'b0);
        push(1, 3'd1, 1'b1);
        @(negedge clk);
        check("t2_gnt_T", 32'(gnt), 0);
        step();
        @(negedge clk);
        check("t2_gnt_T1", 32'(gnt), 32'b0010);
        check("t2_rom_addr", 32'(rom_addr), 2);
        req = '0;
        for (int k = 2; k <= 5; k++) begin
            step();
            @(negedge clk);
            check("t2_busy", 32'(busy), (k < 5) ? 1 : 0);
        end

        // 3. address wrap: 6,7,0,1 -> data 3,2,5,4
        step();
        set_req(0, 3'd6, 3'd3);
        push(0, 3'd3, 1'b0);
        push(0, 3'd2, 1'b0);
        push(0, 3'd5, 1'b0);
        push(0, 3'd4, 1'b1);
        exp_a[0] = 3'd7;
        exp_a[1] = 3'd0;
        exp_a[2] = 3'd1;
        @(negedge clk);
        step();
        @(negedge clk);
        check("t3_gnt", 32'(gnt), 32'b0001);
        check("t3_rom_addr0", 32'(rom_addr), 6);
        req = '0;
        for (int k = 0; k < 3; k++) begin
            step();
            @(negedge clk);
            check("t3_rom_addr", 32'(rom_addr), 32'(exp_a[k]));
        end
        step();
        step();
        @(negedge clk);
        check("t3_busy_done", 32'(busy), 0);

        // 4. reset the RR pointer, then all four request single beats
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 3'(i + 3), 3'd0);
        order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;
        prev = -1;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(8, gc);
            check("t4_gnt", 32'(gnt), 32'(1) << order[k]);
            if (k > 0) check("t4_spacing", 32'(gc - prev), 2);
            prev = gc;
            push(order[k], 3'(order[k] + 3) ^ 3'b101, 1'b1);
            if (k == 4) req = '0;
        end
        repeat (3) step();

        // 5. reset during the second beat of a 4-beat burst
        set_req(2, 3'd1, 3'd3);
        push(2, 3'd4, 1'b0);
        wait_gnt(8, gc);
        check("t5_gnt", 32'(gnt), 32'b0100);
        req = '0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("t5_rst_gnt", 32'(gnt), 0);
        check("t5_rst_rd_valid", 32'(rd_valid), 0);
        check("t5_rst_rd_last", 32'(rd_last), 0);
        check("t5_rst_busy", 32'(busy), 0);
        check("t5_rst_rom_addr", 32'(rom_addr), 0);
        repeat (2) step();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("t5_post_rd_valid", 32'(rd_valid), 0);
            check("t5_post_busy", 32'(busy), 0);
            step();
        end

        // 6. requests during a burst wait for IDLE; previous owner 3 is lowest
        set_req(3, 3'd4, 3'd3);
        push(3, 3'd1, 1'b0);
        push(3, 3'd0, 1'b0);
        push(3, 3'd3, 1'b0);
        push(3, 3'd2, 1'b1);
        wait_gnt(8, gc);
        check("t6_gnt3", 32'(gnt), 32'b1000);
        req = '0;
        step();
        set_req(2, 3'd0, 3'd1);
        set_req(3, 3'd5, 3'd0);
        push(2, 3'd5, 1'b0);
        push(2, 3'd4, 1'b1);
        push(3, 3'd0, 1'b1);
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk);
            check("t6_gnt_held_off", 32'(gnt), 0);
            step();
        end
        @(negedge clk);
        check("t6_gnt2", 32'(gnt), 32'b0100);
        req[2] = 1'b0;
        wait_gnt(8, gc);
        check("t6_gnt3_again", 32'(gnt), 32'b1000);
        req = '0;

        // drain
        for (int k = 0; k < 20; k++) begin
            step();
            if (sb.size() == 0 && !busy) break;
        end
        check("sb_empty", 32'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
